lcd_video_capture: RTL and testbench

- Receive side of the parallel RGB565 LCD interface: samples an incoming HSYNC/VSYNC/DE/RGB stream in the pixel_clk domain.
- Measures active geometry and declares lock after stable frames.
- Captures a decimated 256x256 window (every 4th pixel/line) as RGB332 bytes into a 64x64 video_ram write port.
- Used for loopback test of the LCD timing generator and for frame grabbing into the existing video memory.

---
 rtl/lcd_video_pkg.sv | 32 +++
 rtl/lcd_geom_meter.sv | 135 +++++++++++++
 rtl/lcd_video_capture.sv | 142 ++++++++++++++
 tb/tb_lcd_video_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_video_pkg.sv
// Shared LCD timing constants, pixel formats and geometry-lock FSM states
// used by both the timing generator and the capture path.
package lcd_video_pkg;

    localparam int WidthPixel  = 480;
    localparam int HightPixel  = 272;
    localparam int HPulse      = 4;
    localparam int HBackPorch  = 43;
    localparam int HFrontPorch = 8;
    localparam int VPulse      = 4;
    localparam int VBackPorch  = 12;
    localparam int VFrontPorch = 8;

    localparam int R_W      = 5;
    localparam int G_W      = 6;
    localparam int B_W      = 5;
    localparam int RGB565_W = 16;
    localparam int RGB332_W = 8;

    typedef logic [1:0] geom_state_t;

    localparam geom_state_t SEARCH  = 2'd0;
    localparam geom_state_t MEASURE = 2'd1;
    localparam geom_state_t LOCKED  = 2'd2;

    function automatic logic [RGB332_W-1:0] rgb565_to_rgb332(
        input logic [RGB565_W-1:0] p
    );
        return {p[15:13], p[10:8], p[4:3]};
    endfunction

endpackage

// File: rtl/lcd_geom_meter.sv
// Active-geometry meter: DE/VSYNC edge detection, pixel/line counters,
// per-frame h/v size latch and the SEARCH/MEASURE/LOCKED lock tracker.
module lcd_geom_meter
    import lcd_video_pkg::*;
#(
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 11
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             de,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic             locked,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       LOCK_TGT = 8'(LOCK_FRAMES - 1);

    logic             vsync_q;
    logic             de_q;
    logic [CNT_W-1:0] ref_len;
    logic [CNT_W-1:0] line_len;
    logic             mismatch;
    logic [7:0]       lock_cnt;
    geom_state_t      state;

    logic             de_fall;
    logic             vs_fall;
    logic             first_line;
    logic             line_bad;
    logic             good;
    logic [CNT_W-1:0] y_next;
    logic [CNT_W-1:0] ref_eff;
    logic [CNT_W-1:0] len_eff;

    // A line ending on the same cycle as vsync falls is folded in first.
    always_comb begin
        de_fall    = de_q & ~de;
        vs_fall    = vsync_q & ~vsync;
        first_line = de_fall && (y_cnt == '0);
        line_bad   = de_fall && (y_cnt != '0) && (x_cnt != ref_len);
        y_next     = y_cnt;
        if (de_fall && (y_cnt != CNT_MAX))
            y_next = y_cnt + CNT_W'(1);
        ref_eff = first_line ? x_cnt : ref_len;
        len_eff = de_fall ? x_cnt : line_len;
        good    = !(mismatch || line_bad) && (y_next != '0)
               && (len_eff == h_active) && (y_next == v_active);
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            ref_len  <= '0;
            line_len <= '0;
            mismatch <= 1'b0;
        end else begin
            vsync_q <= vsync;
            de_q    <= de;
            if (de_fall)
                x_cnt <= '0;
            else if (de && (x_cnt != CNT_MAX))
                x_cnt <= x_cnt + CNT_W'(1);
            y_cnt <= vs_fall ? '0 : y_next;
            if (first_line)
                ref_len <= x_cnt;
            if (de_fall)
                line_len <= x_cnt;
            if (vs_fall)
                mismatch <= 1'b0;
            else if (line_bad)
                mismatch <= 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            h_active    <= '0;
            v_active    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vs_fall;
            if (vs_fall) begin
                h_active <= ref_eff;
                v_active <= y_next;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            state    <= SEARCH;
            lock_cnt <= '0;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (vs_fall)
                        state <= MEASURE;
                end
                MEASURE: begin
                    if (vs_fall) begin
                        if (!good)
                            lock_cnt <= '0;
                        else begin
                            lock_cnt <= lock_cnt + 8'd1;
                            if (lock_cnt + 8'd1 >= LOCK_TGT)
                                state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad || (vs_fall && !good)) begin
                        state    <= MEASURE;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_video_capture.sv
// RGB565 LCD receiver: locks to geometry, grabs a 4x-decimated 256x256 window
// as RGB332 into a 64x64 RAM. LCD_CAPTURE_HAVG_EN averages 4 pixels per sample.
module lcd_video_capture
    import lcd_video_pkg::*;
#(
    parameter int START_X     = 112,
    parameter int START_Y     = 8,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 11
) (
    input  logic                pixel_clk,
    input  logic                rst,
    input  logic                vid_hsync,
    input  logic                vid_vsync,
    input  logic                vid_de,
    input  logic [R_W-1:0]      vid_r,
    input  logic [G_W-1:0]      vid_g,
    input  logic [B_W-1:0]      vid_b,
    output logic                wr_en,
    output logic [11:0]         wr_addr,
    output logic [RGB332_W-1:0] wr_data,
    output logic [CNT_W-1:0]    h_active,
    output logic [CNT_W-1:0]    v_active,
    output logic                frame_locked,
    output logic                frame_start
);

    logic                s1_hsync;
    logic                s1_vsync;
    logic                s1_de;
    logic [R_W-1:0]      s1_r;
    logic [G_W-1:0]      s1_g;
    logic [B_W-1:0]      s1_b;
    logic [CNT_W-1:0]    x_cnt;
    logic [CNT_W-1:0]    y_cnt;
    logic [CNT_W-1:0]    dx;
    logic [CNT_W-1:0]    dy;
    logic                x_in;
    logic                y_in;
    logic                cap_base;
    logic                cap;
    logic [RGB565_W-1:0] pix;

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else begin
            s1_hsync <= vid_hsync;
            s1_vsync <= vid_vsync;
            s1_de    <= vid_de;
            s1_r     <= vid_r;
            s1_g     <= vid_g;
            s1_b     <= vid_b;
        end
    end

    lcd_geom_meter #(
        .LOCK_FRAMES (LOCK_FRAMES),
        .CNT_W       (CNT_W)
    ) u_meter (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .vsync       (s1_vsync),
        .de          (s1_de),
        .x_cnt       (x_cnt),
        .y_cnt       (y_cnt),
        .h_active    (h_active),
        .v_active    (v_active),
        .locked      (frame_locked),
        .frame_start (frame_start)
    );

    // x_cnt is the pre-increment index, so the first DE pixel sits at 0.
    assign dx   = x_cnt - CNT_W'(START_X);
    assign dy   = y_cnt - CNT_W'(START_Y);
    assign x_in = (32'(x_cnt) >= START_X) && (32'(x_cnt) < START_X + 256);
    assign y_in = (32'(y_cnt) >= START_Y) && (32'(y_cnt) < START_Y + 256);
    assign cap_base = frame_locked && s1_de && x_in && y_in
                   && (dy[1:0] == 2'b00);

`ifdef LCD_CAPTURE_HAVG_EN
    logic [6:0] acc_r;
    logic [7:0] acc_g;
    logic [6:0] acc_b;
    logic [6:0] sum_r;
    logic [7:0] sum_g;
    logic [6:0] sum_b;
    logic       unused_havg;

    assign sum_r = acc_r + {2'b00, s1_r};
    assign sum_g = acc_g + {2'b00, s1_g};
    assign sum_b = acc_b + {2'b00, s1_b};
    assign cap   = cap_base && (dx[1:0] == 2'b11);
    assign pix   = {sum_r[6:2], sum_g[7:2], sum_b[6:2]};
    assign unused_havg = ^{sum_r[1:0], sum_g[1:0], sum_b[1:0]};

    // Group restarts at each aligned column; a line cut short never hits phase 3.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (s1_de) begin
            if (dx[1:0] == 2'b00) begin
                acc_r <= {2'b00, s1_r};
                acc_g <= {2'b00, s1_g};
                acc_b <= {2'b00, s1_b};
            end else begin
                acc_r <= sum_r;
                acc_g <= sum_g;
                acc_b <= sum_b;
            end
        end
    end
`else
    assign cap = cap_base && (dx[1:0] == 2'b00);
    assign pix = {s1_r, s1_g, s1_b};
`endif

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= cap;
            if (cap) begin
                wr_addr <= {dy[7:2], dx[7:2]};
                wr_data <= rgb565_to_rgb332(pix);
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s1_hsync, dx[CNT_W-1:8], dy[CNT_W-1:8]};

endmodule

// File: tb/tb_lcd_video_capture.sv
// Directed bench for lcd_video_capture: lock sequence, capture window,
// short line / short frame unlock and mid-frame reset, on a reduced raster.
module tb_lcd_video_capture;

    localparam int SX  = 4;
    localparam int SY  = 2;
    localparam int CW  = 11;
    localparam int HPW = 2;
    localparam int HBP = 3;
    localparam int ACT = 272;
    localparam int HFP = 3;
    localparam int VPW = 2;
    localparam int VBP = 2;
    localparam int VFP = 2;

    logic          pixel_clk = 1'b0;
    logic          rst = 1'b0;
    logic          vid_hsync = 1'b1;
    logic          vid_vsync = 1'b1;
    logic          vid_de = 1'b0;
    logic [4:0]    vid_r = '0;
    logic [5:0]    vid_g = '0;
    logic [4:0]    vid_b = '0;
    logic          wr_en;
    logic [11:0]   wr_addr;
    logic [7:0]    wr_data;
    logic [CW-1:0] h_active;
    logic [CW-1:0] v_active;
    logic          frame_locked;
    logic          frame_start;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int fs_cnt = 0;
    int by = 0;
    logic        exp_lock = 1'b0;
    logic        vs_lvl = 1'b1;
    logic        pend_en = 1'b0;
    logic [11:0] pend_addr = '0;
    logic [7:0]  pend_data = '0;
    logic [15:0] hist [4];

    lcd_video_capture #(
        .START_X     (SX),
        .START_Y     (SY),
        .LOCK_FRAMES (2),
        .CNT_W       (CW)
    ) dut (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .vid_hsync    (vid_hsync),
        .vid_vsync    (vid_vsync),
        .vid_de       (vid_de),
        .vid_r        (vid_r),
        .vid_g        (vid_g),
        .vid_b        (vid_b),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .h_active     (h_active),
        .v_active     (v_active),
        .frame_locked (frame_locked),
        .frame_start  (frame_start)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(negedge pixel_clk)
        if (frame_start)
            fs_cnt <= fs_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_zero();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_h_active", 32'(h_active), 32'd0);
        chk("rst_v_active", 32'(v_active), 32'd0);
        chk("rst_locked", 32'(frame_locked), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
    endtask

    // One pixel clock; outputs seen here belong to the previous pixel.
    task automatic tick(input logic hs, input logic de, input int bx);
        logic [15:0] pix;
        int ox;
        int oy;
`ifdef LCD_CAPTURE_HAVG_EN
        int sr;
        int sg;
        int sb;
        logic [15:0] avg;
`endif
        pix = de ? (16'(bx * 241) ^ 16'(by << 11)) : 16'h0000;
        vid_hsync = hs;
        vid_vsync = vs_lvl;
        vid_de    = de;
        {vid_r, vid_g, vid_b} = pix;
        @(posedge pixel_clk);
        #1;
        if (wr_en)
            wr_cnt++;
        if (pend_en || wr_en) begin
            chk("wr_en", 32'(wr_en), 32'(pend_en));
            if (pend_en) begin
                chk("wr_addr", 32'(wr_addr), 32'(pend_addr));
                chk("wr_data", 32'(wr_data), 32'(pend_data));
            end
        end
        pend_en = 1'b0;
        if (de) begin
            hist[bx % 4] = pix;
`ifdef LCD_CAPTURE_HAVG_EN
            ox = bx - 3 - SX;
`else
            ox = bx - SX;
`endif
            oy = by - SY;
            if (exp_lock && ox >= 0 && ox < 256 && ox % 4 == 0
                && oy >= 0 && oy < 256 && oy % 4 == 0) begin
                pend_en   = 1'b1;
                pend_addr = {6'(oy >> 2), 6'(ox >> 2)};
`ifdef LCD_CAPTURE_HAVG_EN
                sr = 0;
                sg = 0;
                sb = 0;
                for (int k = 0; k < 4; k++) begin
                    sr += int'(hist[k][15:11]);
                    sg += int'(hist[k][10:5]);
                    sb += int'(hist[k][4:0]);
                end
                avg = {5'(sr / 4), 6'(sg / 4), 5'(sb / 4)};
                pend_data = {avg[15:13], avg[10:8], avg[4:3]};
`else
                pend_data = {pix[15:13], pix[10:8], pix[4:3]};
`endif
            end
        end
    endtask

    task automatic send_line(input int len, input bit watch, input int rst_at);
        for (int i = 0; i < HPW; i++)
            tick(1'b0, 1'b0, 0);
        for (int i = 0; i < HBP; i++)
            tick(1'b1, 1'b0, 0);
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                exp_lock = 1'b0;
                pend_en = 1'b0;
            end
            if (rst_at >= 0 && i == rst_at + 3) begin
                chk_zero();
                rst = 1'b1;
            end
            tick(1'b1, 1'b1, i);
        end
        for (int i = 0; i < HFP; i++) begin
            tick(1'b1, 1'b0, 0);
            if (watch && i == 0)
                chk("lock_hold", 32'(frame_locked), 32'd1);
            if (watch && i == 1)
                chk("lock_drop", 32'(frame_locked), 32'd0);
        end
    endtask

    // Checks at frame start refer to the frame just ended (eh < 0 skips h/v).
    task automatic send_frame(input int nl, input int sy, input int slen,
                              input bit lk, input int eh, input int ev,
                              input int ewr, input int rst_y);
        int wr0;
        int fs0;
        wr0 = wr_cnt;
        fs0 = fs_cnt;
        by = 0;
        vs_lvl = 1'b0;
        for (int l = 0; l < VPW; l++)
            send_line(0, 1'b0, -1);
        vs_lvl = 1'b1;
        chk("frame_locked", 32'(frame_locked), 32'(lk));
        if (eh >= 0) begin
            chk("h_active", 32'(h_active), 32'(eh));
            chk("v_active", 32'(v_active), 32'(ev));
        end
        exp_lock = lk;
        for (int l = 0; l < VBP; l++)
            send_line(0, 1'b0, -1);
        for (int y = 0; y < nl; y++) begin
            by = y;
            send_line((y == sy) ? slen : ACT, y == sy, (y == rst_y) ? 102 : -1);
            if (y == sy)
                exp_lock = 1'b0;
        end
        for (int l = 0; l < VFP; l++)
            send_line(0, 1'b0, -1);
        chk("writes", 32'(wr_cnt - wr0), 32'(ewr));
        chk("frame_start", 32'(fs_cnt - fs0), 32'd1);
    endtask

    initial begin
        int rst_wr;
`ifdef LCD_CAPTURE_HAVG_EN
        rst_wr = 24;
`else
        rst_wr = 25;
`endif
        repeat (4) tick(1'b1, 1'b0, 0);
        chk_zero();
        rst = 1'b1;
        repeat (4) tick(1'b1, 1'b0, 0);
        send_frame(8, -1, 0,   1'b0, 0,   0, 0,      -1);
        send_frame(8, -1, 0,   1'b0, 272, 8, 0,      -1);
        send_frame(8, -1, 0,   1'b1, 272, 8, 128,    -1);
        send_frame(8, 3,  271, 1'b1, 272, 8, 64,     -1);
        send_frame(8, -1, 0,   1'b0, 272, 8, 0,      -1);
        send_frame(8, -1, 0,   1'b1, 272, 8, 128,    -1);
        send_frame(4, -1, 0,   1'b1, 272, 8, 64,     -1);
        send_frame(8, -1, 0,   1'b0, 272, 4, 0,      -1);
        send_frame(8, -1, 0,   1'b0, 272, 8, 0,      -1);
        send_frame(8, -1, 0,   1'b1, 272, 8, 128,    -1);
        send_frame(8, -1, 0,   1'b1, 272, 8, rst_wr, 2);
        send_frame(8, -1, 0,   1'b0, -1,  0, 0,      -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
